// File: rtl/step_sequencer_if.sv
// Control/datapath bundle between the step sequencer and the core it drives.
// The sequencer side uses master; the datapath, ROM and debug host use slave.
interface step_sequencer_if #(
    parameter int BIT_WIDTH  = 4,
    parameter int INST_WIDTH = 8
);
    logic                  run;
    logic                  step_req;
    logic [INST_WIDTH-1:0] inst_in;
    logic                  alu_cout;
    logic [BIT_WIDTH-1:0]  pc;
    logic [INST_WIDTH-1:0] ir;
    logic                  ir_load;
    logic                  alu_en;
    logic                  reg_we;
    logic                  carry_flag;
    logic                  step_done;
    logic                  busy;
    logic                  halted;

    modport master (
        input  run,
        input  step_req,
        input  inst_in,
        input  alu_cout,
        output pc,
        output ir,
        output ir_load,
        output alu_en,
        output reg_we,
        output carry_flag,
        output step_done,
        output busy,
        output halted
    );

    modport slave (
        output run,
        output step_req,
        output inst_in,
        output alu_cout,
        input  pc,
        input  ir,
        input  ir_load,
        input  alu_en,
        input  reg_we,
        input  carry_flag,
        input  step_done,
        input  busy,
        input  halted
    );
endinterface

// File: rtl/step_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WRITE control FSM owning pc, ir and carry.
// Supports free-running and single-step execution with self-jump halt detect.
module step_sequencer #(
    parameter int BIT_WIDTH    = 4,
    parameter int INST_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    step_sequencer_if.master bus
);
    localparam int TGT_W = INST_WIDTH - OPCODE_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WRITE,
        S_HALT
    } state_t;

    state_t                  state;
    logic [BIT_WIDTH-1:0]    pc_q;
    logic [INST_WIDTH-1:0]   ir_q;
    logic                    carry_q;
    logic                    step_q;
    logic                    stepped;
    logic                    ir_load_q;
    logic                    alu_en_q;
    logic                    reg_we_q;
    logic                    step_done_q;
    logic                    busy_q;
    logic                    halted_q;

    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    is_jmp;
    logic                    is_jc;
    logic                    is_alu;
    logic [BIT_WIDTH-1:0]    target;
    logic [BIT_WIDTH-1:0]    pc_inc;
    logic [BIT_WIDTH-1:0]    pc_next;
    logic                    self_jmp;
    logic                    step_rise;

    assign opcode = ir_q[INST_WIDTH-1 -: OPCODE_WIDTH];
    assign is_jmp = opcode[OPCODE_WIDTH-1];
    assign is_jc  = !opcode[OPCODE_WIDTH-1]
                  && opcode[OPCODE_WIDTH-2];
    assign is_alu = !opcode[OPCODE_WIDTH-1]
                  && !opcode[OPCODE_WIDTH-2];

    // Jump field is truncated or zero-extended to the pc width.
    if (TGT_W >= BIT_WIDTH) begin : g_tgt_trunc
        assign target = ir_q[BIT_WIDTH-1:0];
    end else begin : g_tgt_ext
        assign target = {{(BIT_WIDTH-TGT_W){1'b0}},
                         ir_q[TGT_W-1:0]};
    end

    assign pc_inc    = pc_q + BIT_WIDTH'(1);
    assign self_jmp  = is_jmp && (target == pc_q);
    assign step_rise = bus.step_req && !step_q;

    always_comb begin
        pc_next = pc_inc;
        unique case (1'b1)
            is_jmp:  pc_next = target;
            is_jc:   pc_next = carry_q ? target : pc_inc;
            is_alu:  pc_next = pc_inc;
            default: pc_next = pc_inc;
        endcase
    end

    // Strobes are registered one edge ahead so each is high
    // exactly during the state it belongs to.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            carry_q     <= 1'b0;
            step_q      <= 1'b1;
            stepped     <= 1'b0;
            ir_load_q   <= 1'b0;
            alu_en_q    <= 1'b0;
            reg_we_q    <= 1'b0;
            step_done_q <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            step_q      <= bus.step_req;
            ir_load_q   <= 1'b0;
            alu_en_q    <= 1'b0;
            reg_we_q    <= 1'b0;
            step_done_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.run || step_rise) begin
                        state     <= S_FETCH;
                        stepped   <= !bus.run;
                        ir_load_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_FETCH: begin
                    ir_q  <= bus.inst_in;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    alu_en_q <= is_alu;
                    state    <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_alu) begin
                        carry_q <= bus.alu_cout;
                    end
                    reg_we_q    <= is_alu;
                    step_done_q <= stepped;
                    state       <= S_WRITE;
                end
                S_WRITE: begin
                    pc_q <= pc_next;
                    if (self_jmp) begin
                        state    <= S_HALT;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else if (!stepped && bus.run) begin
                        state     <= S_FETCH;
                        ir_load_q <= 1'b1;
                    end else begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc         = pc_q;
    assign bus.ir         = ir_q;
    assign bus.ir_load    = ir_load_q;
    assign bus.alu_en     = alu_en_q;
    assign bus.reg_we     = reg_we_q;
    assign bus.carry_flag = carry_q;
    assign bus.step_done  = step_done_q;
    assign bus.busy       = busy_q;
    assign bus.halted     = halted_q;
endmodule
